// File: rtl/capture_pkg.sv
// Shared types and helpers for the capture sequencer.
package capture_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    ARMED = 3'd2,
    POST  = 3'd3,
    DONE  = 3'd4
  } cap_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'(1) << addr_w;
  endfunction

endpackage

// File: rtl/trig_combine.sv
// Combines per-channel trigger outputs into one fire strobe (all-of or any-of).
module trig_combine #(
  parameter int unsigned NUM_CH = 5
) (
  input  logic [NUM_CH-1:0] i_ch_trig,
  input  logic              i_trig_and,
  output logic              o_fire
);

  assign o_fire = i_trig_and ? (&i_ch_trig) : (|i_ch_trig);

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills pre-trigger history, waits for the combined trigger,
// records a fixed number of post-trigger samples into a circular sample RAM.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned NUM_CH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              clr_done,
  input  logic              smpl_en,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              trig_and,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              set_armed,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  cap_state_t        r_state;
  cap_state_t        w_next_state;
  logic [ADDR_W-1:0] r_trig_pos;
  logic [ADDR_W-1:0] r_fill_cnt;
  logic [ADDR_W-1:0] r_post_cnt;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] r_trig_addr;
  logic              r_set_armed;
  logic              r_triggered;
  logic              r_capture_done;

  logic              w_fire;
  logic              w_we;
  logic              w_trig_hit;
  logic [ADDR_W-1:0] w_pre_target;
  logic [ADDR_W-1:0] w_pre_target_start;

  trig_combine #(
    .NUM_CH (NUM_CH)
  ) u_trig_combine (
    .i_ch_trig  (ch_trig),
    .i_trig_and (trig_and),
    .o_fire     (w_fire)
  );

  // Pre-trigger history length; the start-cycle copy uses the live trig_pos.
  assign w_pre_target       = ADDR_W'(DEPTH - 1) - r_trig_pos;
  assign w_pre_target_start = ADDR_W'(DEPTH - 1) - trig_pos;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (start) begin
      w_next_state = (w_pre_target_start != '0) ? FILL : ARMED;
    end else begin
      case (r_state)
        IDLE: w_next_state = IDLE;
        FILL: begin
          if (smpl_en && ((r_fill_cnt + ADDR_W'(1)) == w_pre_target)) begin
            w_next_state = ARMED;
          end
        end
        ARMED: begin
          if (smpl_en && w_fire) begin
            w_next_state = (r_trig_pos == '0) ? DONE : POST;
          end
        end
        POST: begin
          if (smpl_en && ((r_post_cnt + ADDR_W'(1)) == r_trig_pos)) begin
            w_next_state = DONE;
          end
        end
        DONE: begin
          if (clr_done) begin
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  always_comb begin
    w_we       = 1'b0;
    w_trig_hit = 1'b0;
    case (r_state)
      FILL, POST: w_we = smpl_en && !rst;
      ARMED: begin
        w_we       = smpl_en && !rst;
        w_trig_hit = smpl_en && w_fire && !start;
      end
      default: begin
        w_we       = 1'b0;
        w_trig_hit = 1'b0;
      end
    endcase
  end

  // Counters, write pointer and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_trig_pos     <= '0;
      r_fill_cnt     <= '0;
      r_post_cnt     <= '0;
      r_waddr        <= '0;
      r_trig_addr    <= '0;
      r_set_armed    <= 1'b0;
      r_triggered    <= 1'b0;
      r_capture_done <= 1'b0;
    end else if (start) begin
      r_trig_pos     <= trig_pos;
      r_fill_cnt     <= '0;
      r_post_cnt     <= '0;
      r_waddr        <= '0;
      r_set_armed    <= 1'b0;
      r_triggered    <= 1'b0;
      r_capture_done <= 1'b0;
    end else begin
      r_set_armed <= (r_state == ARMED) || (r_state == POST);
      if (w_we) begin
        r_waddr <= r_waddr + ADDR_W'(1);
      end
      if ((r_state == FILL) && smpl_en) begin
        r_fill_cnt <= r_fill_cnt + ADDR_W'(1);
      end
      if (w_trig_hit) begin
        r_trig_addr <= r_waddr;
        r_triggered <= 1'b1;
        r_post_cnt  <= '0;
      end else if ((r_state == POST) && smpl_en) begin
        r_post_cnt <= r_post_cnt + ADDR_W'(1);
      end
      if ((r_state != DONE) && (w_next_state == DONE)) begin
        r_capture_done <= 1'b1;
      end else if ((r_state == DONE) && clr_done) begin
        r_capture_done <= 1'b0;
      end
    end
  end

  assign we           = w_we;
  assign waddr        = r_waddr;
  assign set_armed    = r_set_armed;
  assign triggered    = r_triggered;
  assign capture_done = r_capture_done;
  assign trig_addr    = r_trig_addr;

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl with directed scenarios and a randomized run.
module tb_capture_ctrl;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NUM_CH = 5;
  localparam int DEPTH = 16;
  localparam int P_IDLE = 0, P_PRE = 1, P_POST = 2, P_DONE = 3;

  logic              clk = 1'b0;
  logic              rst, start, clr_done, smpl_en, trig_and;
  logic [NUM_CH-1:0] ch_trig;
  logic [ADDR_W-1:0] trig_pos;
  logic              set_armed, we, triggered, capture_done;
  logic [ADDR_W-1:0] waddr, trig_addr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase, writes since start, post-trigger writes.
  int m_phase = P_IDLE, m_n = 0, m_post = 0, m_tp = 0, m_pre = 0, m_taddr = 0;
  bit m_trig = 0, m_done = 0, m_armed = 0;
  bit obs_we, exp_we;

  capture_ctrl #(
    .ADDR_W (ADDR_W),
    .NUM_CH (NUM_CH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .clr_done     (clr_done),
    .smpl_en      (smpl_en),
    .ch_trig      (ch_trig),
    .trig_and     (trig_and),
    .trig_pos     (trig_pos),
    .set_armed    (set_armed),
    .we           (we),
    .waddr        (waddr),
    .triggered    (triggered),
    .capture_done (capture_done),
    .trig_addr    (trig_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One clock: sample we, advance the model across the edge, return at negedge.
  task automatic tick();
    bit fire, armed_now;
    #1;
    obs_we    = we;
    exp_we    = !rst && smpl_en && (m_phase == P_PRE || m_phase == P_POST);
    fire      = trig_and ? (ch_trig == 5'b11111) : (ch_trig != 5'b00000);
    armed_now = (m_phase == P_PRE && m_n >= m_pre) || (m_phase == P_POST);
    @(posedge clk);
    if (rst) begin
      m_phase = P_IDLE; m_n = 0; m_trig = 0; m_done = 0; m_taddr = 0; m_armed = 0;
    end else if (start) begin
      m_tp = int'(trig_pos); m_pre = DEPTH - 1 - m_tp;
      m_phase = P_PRE; m_n = 0; m_trig = 0; m_done = 0; m_armed = 0;
    end else begin
      m_armed = armed_now;
      case (m_phase)
        P_PRE: if (smpl_en) begin
          if (m_n >= m_pre && fire) begin
            m_taddr = m_n % DEPTH; m_trig = 1; m_post = 0;
            if (m_tp == 0) begin m_phase = P_DONE; m_done = 1; end
            else m_phase = P_POST;
          end
          m_n++;
        end
        P_POST: if (smpl_en) begin
          m_n++; m_post++;
          if (m_post == m_tp) begin m_phase = P_DONE; m_done = 1; end
        end
        P_DONE: if (clr_done) begin m_phase = P_IDLE; m_done = 0; end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic drive_idle();
    rst = 0; start = 0; clr_done = 0; smpl_en = 0; trig_and = 0; ch_trig = '0;
  endtask

  task automatic pulse_start(input logic [ADDR_W-1:0] tp);
    drive_idle(); trig_pos = tp; start = 1; tick(); start = 0;
  endtask

  task automatic test_reset();
    drive_idle(); rst = 1; smpl_en = 1; trig_pos = '0;
    tick(); tick();
    n_tests++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b exp 0", obs_we); end
    n_tests++;
    if ({set_armed, triggered, capture_done} !== 3'b000 || waddr !== '0 || trig_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got armed=%0b trig=%0b done=%0b waddr=%0d taddr=%0d exp all 0",
               set_armed, triggered, capture_done, waddr, trig_addr);
    end
    rst = 0; tick();
    n_tests++; if (waddr !== '0) begin n_fail++; $display("FAIL reset_idle_waddr got %0d exp 0", waddr); end
  endtask

  task automatic test_basic();
    pulse_start(4'd5);
    smpl_en = 1;
    for (int i = 1; i <= 20; i++) begin
      ch_trig = (i == 20) ? 5'b00001 : 5'b00000;
      tick();
      n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL basic_we write=%0d got %0b exp 1", i, obs_we); end
      if (i == 10) begin
        n_tests++; if (set_armed !== 1'b0) begin n_fail++; $display("FAIL basic_armed_early got %0b exp 0", set_armed); end
      end
      if (i == 11) begin
        n_tests++; if (set_armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed got %0b exp 1", set_armed); end
      end
    end
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd3) begin
      n_fail++; $display("FAIL basic_trigger got trig=%0b taddr=%0d exp 1/3", triggered, trig_addr);
    end
    ch_trig = '0;
    for (int j = 1; j <= 5; j++) begin
      tick();
      n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL basic_post_we j=%0d got %0b exp 1", j, obs_we); end
    end
    n_tests++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL basic_done got %0b exp 1", capture_done); end
    tick();
    n_tests++;
    if (obs_we !== 1'b0 || capture_done !== 1'b1 || trig_addr !== 4'd3 || waddr !== 4'd9 || set_armed !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_final got we=%0b done=%0b taddr=%0d waddr=%0d armed=%0b exp 0/1/3/9/0",
               obs_we, capture_done, trig_addr, waddr, set_armed);
    end
  endtask

  task automatic test_immediate_arm();
    pulse_start(4'd15);
    n_tests++; if (set_armed !== 1'b0) begin n_fail++; $display("FAIL imm_armed_start got %0b exp 0", set_armed); end
    tick();
    n_tests++; if (set_armed !== 1'b1) begin n_fail++; $display("FAIL imm_armed got %0b exp 1", set_armed); end
    smpl_en = 1; ch_trig = 5'b10000;
    tick();
    n_tests++;
    if (obs_we !== 1'b1 || triggered !== 1'b1 || trig_addr !== 4'd0) begin
      n_fail++; $display("FAIL imm_trigger got we=%0b trig=%0b taddr=%0d exp 1/1/0", obs_we, triggered, trig_addr);
    end
    ch_trig = '0;
    for (int j = 1; j <= 15; j++) begin
      tick();
      n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL imm_post_we j=%0d got %0b exp 1", j, obs_we); end
    end
    tick();
    n_tests++;
    if (obs_we !== 1'b0 || capture_done !== 1'b1 || waddr !== 4'd0) begin
      n_fail++; $display("FAIL imm_done got we=%0b done=%0b waddr=%0d exp 0/1/0", obs_we, capture_done, waddr);
    end
  endtask

  task automatic test_no_post();
    pulse_start(4'd0);
    smpl_en = 1;
    for (int i = 1; i <= 16; i++) begin
      ch_trig = (i == 16) ? 5'b00010 : 5'b00000;
      tick();
    end
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd15 || capture_done !== 1'b1) begin
      n_fail++; $display("FAIL nopost_trigger got trig=%0b taddr=%0d done=%0b exp 1/15/1", triggered, trig_addr, capture_done);
    end
    ch_trig = '0;
    tick();
    n_tests++;
    if (obs_we !== 1'b0 || waddr !== 4'd0) begin
      n_fail++; $display("FAIL nopost_we got we=%0b waddr=%0d exp 0/0", obs_we, waddr);
    end
  endtask

  task automatic test_and_or();
    pulse_start(4'd3);
    smpl_en = 1;
    for (int i = 0; i < 12; i++) tick();
    ch_trig = 5'b00101; trig_and = 1;
    for (int i = 0; i < 4; i++) tick();
    n_tests++; if (triggered !== 1'b0) begin n_fail++; $display("FAIL and_nofire got %0b exp 0", triggered); end
    trig_and = 0;
    tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd0) begin
      n_fail++; $display("FAIL or_fire got trig=%0b taddr=%0d exp 1/0", triggered, trig_addr);
    end
    ch_trig = '0;
    for (int i = 0; i < 3; i++) tick();
    n_tests++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL andor_done got %0b exp 1", capture_done); end
  endtask

  task automatic test_sparse();
    int n_smpl, n_we;
    pulse_start(4'd4);
    n_smpl = 0; n_we = 0;
    for (int c = 0; c < 60; c++) begin
      smpl_en = ((c % 3) == 2);
      ch_trig = smpl_en ? 5'b00000 : 5'b11111;
      n_smpl += int'(smpl_en);
      tick();
      n_we += int'(obs_we);
    end
    n_tests++; if (n_we !== n_smpl) begin n_fail++; $display("FAIL sparse_count got %0d writes exp %0d", n_we, n_smpl); end
    n_tests++;
    if (triggered !== 1'b0 || waddr !== 4'd4) begin
      n_fail++; $display("FAIL sparse_gate got trig=%0b waddr=%0d exp 0/4", triggered, waddr);
    end
    smpl_en = 1; ch_trig = 5'b01000;
    tick();
    n_tests++;
    if (triggered !== 1'b1 || trig_addr !== 4'd4) begin
      n_fail++; $display("FAIL sparse_fire got trig=%0b taddr=%0d exp 1/4", triggered, trig_addr);
    end
  endtask

  task automatic test_reset_restart();
    pulse_start(4'd2);
    smpl_en = 1;
    for (int i = 0; i < 13; i++) tick();
    ch_trig = 5'b00001; tick(); ch_trig = '0; tick();
    rst = 1;
    tick();
    n_tests++; if (obs_we !== 1'b0) begin n_fail++; $display("FAIL rst_post_we got %0b exp 0", obs_we); end
    n_tests++;
    if ({set_armed, triggered, capture_done} !== 3'b000 || waddr !== '0 || trig_addr !== '0) begin
      n_fail++;
      $display("FAIL rst_post_outputs got armed=%0b trig=%0b done=%0b waddr=%0d taddr=%0d exp all 0",
               set_armed, triggered, capture_done, waddr, trig_addr);
    end
    rst = 0; smpl_en = 0;
    tick();
    for (int rep = 0; rep < 2; rep++) begin
      pulse_start(4'd15);
      smpl_en = 1; ch_trig = 5'b00001;
      for (int i = 0; i < 16; i++) tick();
      n_tests++; if (capture_done !== 1'b1) begin n_fail++; $display("FAIL restart_pre_done rep=%0d got %0b exp 1", rep, capture_done); end
      ch_trig = '0; smpl_en = 0; trig_pos = 4'd15;
      start = 1; clr_done = (rep == 1);
      tick();
      start = 0; clr_done = 0;
      n_tests++;
      if (capture_done !== 1'b0 || waddr !== 4'd0 || triggered !== 1'b0) begin
        n_fail++; $display("FAIL restart rep=%0d got done=%0b waddr=%0d trig=%0b exp 0/0/0", rep, capture_done, waddr, triggered);
      end
      smpl_en = 1;
      tick();
      n_tests++; if (obs_we !== 1'b1) begin n_fail++; $display("FAIL restart_we rep=%0d got %0b exp 1", rep, obs_we); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst      = ($urandom_range(0, 299) == 0);
      start    = ($urandom_range(0, 49) == 0);
      clr_done = (m_phase == P_DONE) && ($urandom_range(0, 9) == 0);
      smpl_en  = 1'($urandom_range(0, 1));
      trig_and = ($urandom_range(0, 3) == 0);
      if (trig_and) ch_trig = ($urandom_range(0, 2) == 0) ? 5'b11111 : 5'($urandom());
      else          ch_trig = ($urandom_range(0, 7) == 0) ? 5'($urandom()) : 5'b00000;
      case ($urandom_range(0, 3))
        0:       trig_pos = 4'd0;
        1:       trig_pos = 4'd15;
        default: trig_pos = 4'($urandom_range(0, 15));
      endcase
      tick();
      n_tests++; if (obs_we !== exp_we) begin n_fail++; $display("FAIL rnd_we c=%0d got %0b exp %0b", c, obs_we, exp_we); end
      n_tests++;
      if (waddr !== 4'(m_n % DEPTH) || set_armed !== m_armed || triggered !== m_trig ||
          capture_done !== m_done || trig_addr !== 4'(m_taddr)) begin
        n_fail++;
        $display("FAIL rnd_state c=%0d got waddr=%0d armed=%0b trig=%0b done=%0b taddr=%0d exp %0d/%0b/%0b/%0b/%0d",
                 c, waddr, set_armed, triggered, capture_done, trig_addr,
                 m_n % DEPTH, m_armed, m_trig, m_done, m_taddr);
      end
    end
  endtask

  initial begin
    drive_idle();
    trig_pos = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_immediate_arm();
    test_no_post();
    test_and_or();
    test_sparse();
    test_reset_restart();
    test_random();
    drive_idle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
